uart_rx: RTL and testbench

Serial receiver paired with `uart_tx`; consumes the `tx` line produced by the transmitter, timed by the same `mod_m_counter` 16x oversampling tick (`s_tick`). Synchronises the asynchronous `rx` input, validates the start bit, shifts in DBIT data bits LSB-first, checks the stop bit, and writes each good byte into the downstream RX FIFO with a one-cycle write strobe. Framing and overrun errors are flagged and sticky until cleared.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_rx.sv | 103 ++++++++++
 tb/tb_uart_rx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, oversampling constant, frame defaults and counter sizing
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int DBIT_DEF = 8;
  localparam int SB_TICK_DEF = 16;
  // Tick counter must reach SB_TICK-1, so two stop bits need a fifth bit
  function automatic int cnt_w(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? 5 : 4;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// rx_sync: 2-flop synchroniser for an asynchronous input
//   clk, reset (sync, active-low), d async in, q synchronised out (RST_VAL while in reset)
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q;
  always_ff @(posedge clk)
    if (!reset) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], d};
  assign q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with FIFO write strobe and sticky error flags
//   in : clk, reset (sync, active-low), rx, s_tick, rx_fifo_full, err_clr
//   out: rx_dout, rx_fifo_wr, rx_busy, rx_frame_err, rx_overrun
module uart_rx import uart_pkg::*; #(
  parameter int DBIT = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rx_fifo_full,
  input  logic            err_clr,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_fifo_wr,
  output logic            rx_busy,
  output logic            rx_frame_err,
  output logic            rx_overrun
);
  localparam int SW = cnt_w(SB_TICK);
  rx_state_e state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [DBIT-1:0] b_q, b_d, dout_q, dout_d;
  logic wr_q, wr_d, fe_q, fe_d, ov_q, ov_d, fe_set, ov_set, rx_s;
  rx_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    b_d = b_q;
    dout_d = dout_q;
    wr_d = 1'b0;
    fe_set = 1'b0;
    ov_set = 1'b0;
    case (state_q)
      IDLE:
        if (!rx_s) begin
          state_d = START;
          s_d = '0;
        end
      START:
        if (s_tick) begin
          if (s_q == SW'(OVERSAMPLE / 2 - 1)) begin
            // still low at mid start bit: genuine start, otherwise a glitch
            state_d = rx_s ? IDLE : DATA;
            s_d = '0;
            n_d = '0;
          end else s_d = s_q + 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == 3'(DBIT - 1)) state_d = STOP;
            else n_d = n_q + 1'b1;
          end else s_d = s_q + 1'b1;
        end
      STOP:
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            if (!rx_s) fe_set = 1'b1;
            else if (rx_fifo_full) ov_set = 1'b1;
            else begin
              dout_d = b_q;
              wr_d = 1'b1;
            end
          end else s_d = s_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
    // a new error in the same cycle as err_clr stays set
    fe_d = fe_set | (fe_q & ~err_clr);
    ov_d = ov_set | (ov_q & ~err_clr);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      s_q <= '0;
      n_q <= '0;
      b_q <= '0;
      dout_q <= '0;
      wr_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      b_q <= b_d;
      dout_q <= dout_d;
      wr_q <= wr_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  assign rx_dout = dout_q;
  assign rx_fifo_wr = wr_q;
  assign rx_busy = state_q != IDLE;
  assign rx_frame_err = fe_q;
  assign rx_overrun = ov_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level reference model
module tb_uart_rx;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1, s_tick = 1'b0, rx_fifo_full = 1'b0, err_clr = 1'b0;
  logic [7:0] rx_dout;
  logic rx_fifo_wr, rx_busy, rx_frame_err, rx_overrun;
  logic [1:0] tcnt = 2'd0;
  int checks = 0, errors = 0;
  int tick_total = 0, fall_snap = 0, last_lat = 0, wr_cnt = 0;
  logic [7:0] exp_dout = 8'h00;
  int exp_wr = 0;
  logic exp_fe = 1'b0, exp_ov = 1'b0;
  uart_rx dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .rx_fifo_full(rx_fifo_full),
    .err_clr(err_clr), .rx_dout(rx_dout), .rx_fifo_wr(rx_fifo_wr), .rx_busy(rx_busy),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
  end
  // ticks counted here are those the DUT will see on the following rising edge
  always @(negedge clk) begin
    if (rx_fifo_wr) begin
      wr_cnt++;
      last_lat = tick_total - fall_snap;
    end
    if (s_tick) tick_total++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      while (!s_tick) begin
        @(posedge clk); #1;
      end
    end
  endtask
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    tick_wait(n);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic full);
    rx_fifo_full = full;
    fall_snap = tick_total;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    if (stop_ok) drive_bit(1'b1, 16);
    else begin
      drive_bit(1'b0, 12);
      drive_bit(1'b1, 16);
    end
    rx_fifo_full = 1'b0;
    if (!stop_ok) exp_fe = 1'b1;
    else if (full) exp_ov = 1'b1;
    else begin
      exp_dout = d;
      exp_wr++;
    end
  endtask
  task automatic check_frame(input string tag, input logic written);
    chk({tag, "_wrcnt"}, wr_cnt, exp_wr);
    chk({tag, "_dout"}, {24'h0, rx_dout}, {24'h0, exp_dout});
    chk({tag, "_fe"}, {31'h0, rx_frame_err}, {31'h0, exp_fe});
    chk({tag, "_ov"}, {31'h0, rx_overrun}, {31'h0, exp_ov});
    chk({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
    chk({tag, "_wr_low"}, {31'h0, rx_fifo_wr}, 32'h0);
    if (written) chk({tag, "_lat152"}, {31'h0, (last_lat >= 152 && last_lat <= 153)}, 32'h1);
  endtask
  task automatic clear_errs();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask
  initial begin
    logic [7:0] d;
    logic ok, full;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_dout", {24'h0, rx_dout}, 32'h0);
    chk("rst_wr", {31'h0, rx_fifo_wr}, 32'h0);
    chk("rst_busy", {31'h0, rx_busy}, 32'h0);
    chk("rst_fe", {31'h0, rx_frame_err}, 32'h0);
    chk("rst_ov", {31'h0, rx_overrun}, 32'h0);
    reset = 1'b1;
    tick_wait(20);
    send_frame(8'h55, 1'b1, 1'b0);
    check_frame("f55", 1'b1);
    send_frame(8'hA3, 1'b1, 1'b0);
    check_frame("fA3", 1'b1);
    rx = 1'b0;
    tick_wait(3);
    chk("glitch_busy_hi", {31'h0, rx_busy}, 32'h1);
    tick_wait(2);
    rx = 1'b1;
    tick_wait(16);
    check_frame("glitch", 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    check_frame("ferr", 1'b0);
    clear_errs();
    check_frame("ferr_clr", 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1);
    check_frame("ovr", 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    check_frame("ovr_next", 1'b1);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    chk("mid_busy", {31'h0, rx_busy}, 32'h1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("mrst_dout", {24'h0, rx_dout}, 32'h0);
    chk("mrst_busy", {31'h0, rx_busy}, 32'h0);
    chk("mrst_ov", {31'h0, rx_overrun}, 32'h0);
    chk("mrst_fe", {31'h0, rx_frame_err}, 32'h0);
    exp_dout = 8'h00;
    exp_ov = 1'b0;
    exp_fe = 1'b0;
    tick_wait(80);
    check_frame("mrst_idle", 1'b0);
    send_frame(8'h12, 1'b1, 1'b0);
    check_frame("f12", 1'b1);
    send_frame(8'h00, 1'b1, 1'b0);
    check_frame("b2b00", 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0);
    check_frame("b2bFF", 1'b1);
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      full = ($urandom_range(3) == 0);
      ok = ($urandom_range(4) != 0);
      send_frame(d, ok, full);
      check_frame("rnd", ok && !full);
      if ($urandom_range(2) == 0) begin
        clear_errs();
        check_frame("rnd_clr", 1'b0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
